// File: rtl/not_gate_pipe.sv
// Elastic valid/ready pipeline that applies a per-word invert/pass/masked-invert transform.
// Optional macro NOT_GATE_PARITY_EN adds an out_parity bit carried alongside each word.
module not_gate_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef NOT_GATE_PARITY_EN
  output logic             out_parity,
`endif
  output logic             busy
);

`ifdef NOT_GATE_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  function automatic logic [WIDTH-1:0] transform(
    input logic [WIDTH-1:0] data,
    input logic [1:0]       op,
    input logic [WIDTH-1:0] msk
  );
    logic [WIDTH-1:0] res;
    case (op)
      2'b00:   res = ~data;
      2'b01:   res = data;
      2'b10:   res = data ^ msk;
      2'b11:   res = data ^ ~msk;
      default: res = ~data;
    endcase
    return res;
  endfunction

`ifdef NOT_GATE_PARITY_EN
  function automatic logic parity_of(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  logic [WIDTH-1:0] xf_s;
  logic [SW-1:0]    stage_in_s;
  logic [STAGES:0]  r_s;
  logic             v_s [STAGES];
  logic [SW-1:0]    d_s [STAGES];
  logic [STAGES-1:0] v_vec_s;

  // transform the incoming word (and attach its parity when enabled)
  always_comb begin
    xf_s = transform(in_data, mode, mask);
`ifdef NOT_GATE_PARITY_EN
    stage_in_s = {parity_of(xf_s), xf_s};
`else
    stage_in_s = xf_s;
`endif
  end

  assign r_s[STAGES] = out_ready;
  assign in_ready    = r_s[0];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic          v_r;
    logic [SW-1:0] d_r;
    logic          up_v_s;
    logic [SW-1:0] up_d_s;

    if (g == 0) begin : g_first
      assign up_v_s = in_valid;
      assign up_d_s = stage_in_s;
    end else begin : g_later
      assign up_v_s = v_s[g-1];
      assign up_d_s = d_s[g-1];
    end

    // an empty stage always accepts, so bubbles collapse under a stall
    assign r_s[g]     = ~v_r | r_s[g+1];
    assign v_s[g]     = v_r;
    assign d_s[g]     = d_r;
    assign v_vec_s[g] = v_r;

    // stage register; data only moves on a real word, never on a bubble
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_r <= 1'b0;
        d_r <= '0;
      end else if (r_s[g]) begin
        v_r <= up_v_s;
        if (up_v_s) begin
          d_r <= up_d_s;
        end
      end
    end
  end

  assign out_valid = v_s[STAGES-1];
  assign out_data  = d_s[STAGES-1][WIDTH-1:0];
`ifdef NOT_GATE_PARITY_EN
  assign out_parity = d_s[STAGES-1][WIDTH];
`endif
  assign busy = |v_vec_s;

endmodule
